// File: rtl/mt32_frame_scheduler.sv
// MT-32 DAC slot collector: rebuilds {left,right} frames from the time-multiplexed
// DAC stream, mixes SYN/REV channels and buffers frames toward the serializer.
module mt32_frame_scheduler #(
  parameter logic [15:0] OFFSET     = 16'd16344,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        mclk,
  input  logic        rst,
  input  logic        clk_inh,
  input  logic [2:0]  ch_id,
  input  logic [15:0] dac,
  input  logic        rev_sw,
  input  logic        frame_req,
  output logic [31:0] frame_data,
  output logic [1:0]  fifo_level,
  output logic        overrun,
  output logic        underrun,
  output logic        slot_err
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned SW = 18;

  typedef enum logic [1:0] {ST_ALIGN, ST_COLLECT, ST_MIX, ST_PUSH} state_t;

  state_t        r_state, w_state_nxt;
  logic          r_inh_s1, r_inh_s2, r_inh_s3, r_strobe;
  logic [2:0]    r_ch_s1, r_ch_s2;
  logic          r_rev_s1, r_rev_s2, r_req_d;
  logic [15:0]   r_chan [6];
  logic [5:0]    r_mask, w_mask_nxt, w_ch_hit;
  logic          w_is4, w_slot_err_nxt, w_mix_en, w_push;
  logic [15:0]   r_left, r_right, w_left, w_right;
  logic [SW-1:0] w_sum_l, w_sum_r;
  logic [31:0]   r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wr, r_rd;
  logic [CW-1:0] r_count;
  logic          w_pop, w_empty, w_full, w_do_pop, w_do_push;

  // Synchronizers, INH falling-edge strobe and request edge history
  always_ff @(posedge mclk) begin
    if (rst) begin
      r_inh_s1 <= 1'b0; r_inh_s2 <= 1'b0; r_inh_s3 <= 1'b0; r_strobe <= 1'b0;
      r_ch_s1  <= '0;   r_ch_s2  <= '0;
      r_rev_s1 <= 1'b0; r_rev_s2 <= 1'b0; r_req_d  <= 1'b0;
    end else begin
      r_inh_s1 <= clk_inh;  r_inh_s2 <= r_inh_s1; r_inh_s3 <= r_inh_s2;
      r_strobe <= r_inh_s3 & ~r_inh_s2;
      r_ch_s1  <= ch_id;    r_ch_s2  <= r_ch_s1;
      r_rev_s1 <= rev_sw;   r_rev_s2 <= r_rev_s1;
      r_req_d  <= frame_req;
    end
  end

  // Slot map: bit order LSYN1, RSYN1, LSYN2, RSYN2, LREV, RREV
  always_comb begin
    w_ch_hit = '0;
    case (r_ch_s2)
      3'd3:    w_ch_hit = 6'b000001;
      3'd7:    w_ch_hit = 6'b000010;
      3'd2:    w_ch_hit = 6'b000100;
      3'd6:    w_ch_hit = 6'b001000;
      3'd0:    w_ch_hit = 6'b010000;
      3'd1:    w_ch_hit = 6'b100000;
      default: w_ch_hit = '0;
    endcase
    if (!r_strobe) w_ch_hit = '0;
  end

  assign w_is4 = r_strobe && (r_ch_s2 == 3'd4);

  always_ff @(posedge mclk) begin
    for (int i = 0; i < 6; i++) begin
      if (rst)              r_chan[i] <= '0;
      else if (w_ch_hit[i]) r_chan[i] <= dac;
    end
  end

  always_ff @(posedge mclk) begin
    if (rst) begin
      r_state  <= ST_ALIGN;
      r_mask   <= '0;
      slot_err <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_mask   <= w_mask_nxt;
      slot_err <= w_slot_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_mask_nxt     = r_mask | w_ch_hit;
    w_slot_err_nxt = 1'b0;
    w_mix_en       = 1'b0;
    w_push         = 1'b0;
    case (r_state)
      ST_ALIGN: begin
        if (w_is4) begin
          w_mask_nxt  = '0;
          w_state_nxt = ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        if (w_is4) begin
          if (r_mask == 6'b111111) begin
            w_state_nxt = ST_MIX;
          end else begin
            w_slot_err_nxt = 1'b1;
            w_mask_nxt     = '0;
          end
        end
      end
      ST_MIX: begin
        w_mix_en    = 1'b1;
        w_state_nxt = ST_PUSH;
      end
      ST_PUSH: begin
        w_push      = 1'b1;
        w_mask_nxt  = '0;
        w_state_nxt = ST_COLLECT;
      end
      default: w_state_nxt = ST_ALIGN;
    endcase
  end

  // 18-bit mix, then wrap-around offset removal
  assign w_sum_l = r_rev_s2 ? (SW'(r_chan[0]) + SW'(r_chan[2]) + SW'(r_chan[4])) : SW'(r_chan[0]);
  assign w_sum_r = r_rev_s2 ? (SW'(r_chan[1]) + SW'(r_chan[3]) + SW'(r_chan[5])) : SW'(r_chan[1]);
  assign w_left  = 16'(w_sum_l - SW'(OFFSET));
  assign w_right = 16'(w_sum_r - SW'(OFFSET));

  always_ff @(posedge mclk) begin
    if (rst) begin
      r_left  <= '0;
      r_right <= '0;
    end else if (w_mix_en) begin
      r_left  <= w_left;
      r_right <= w_right;
    end
  end

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (32'(p) == FIFO_DEPTH - 1) ? '0 : p + PW'(1);
  endfunction

  assign w_pop     = frame_req & ~r_req_d;
  assign w_empty   = (r_count == '0);
  assign w_full    = (32'(r_count) == FIFO_DEPTH);
  assign w_do_pop  = w_pop & ~w_empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts
  assign w_do_push = w_push & (~w_full | w_do_pop);

  always_ff @(posedge mclk) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wr       <= '0;
      r_rd       <= '0;
      r_count    <= '0;
      frame_data <= '0;
      overrun    <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr] <= {r_left, r_right};
        r_wr        <= ptr_inc(r_wr);
      end
      if (w_do_pop) begin
        frame_data <= r_mem[r_rd];
        r_rd       <= ptr_inc(r_rd);
      end
      if (w_pop && w_empty)      underrun <= 1'b1;
      if (w_push && !w_do_push)  overrun  <= 1'b1;
      r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
    end
  end

  assign fifo_level = 2'(r_count);

endmodule

// File: doc/mt32_frame_scheduler.md
MT32_FRAME_SCHEDULER -- requirements
Module: mt32_frame_scheduler

Interface
REQ-001 SHALL have parameter OFFSET, default 16'd16344, meaning the digital DC offset subtracted from each mixed channel.
REQ-002 SHALL have parameter FIFO_DEPTH, default 2, meaning the number of 32-bit frames buffered toward the serializer.
REQ-003 SHALL have port mclk, input, 1, meaning the single clock (16.384 MHz); every flop SHALL be clocked on its rising edge.
REQ-004 SHALL have port rst, input, 1, meaning the reset, which is synchronous and active-high.
REQ-005 SHALL have port clk_inh, input, 1, meaning the 256 kHz INH strobe; it is asynchronous to mclk.
REQ-006 SHALL have port ch_id, input, 3, meaning the cd4051 slot select a/b/c; it is asynchronous.
REQ-007 SHALL have port dac, input, 16, meaning the parallel DAC word; it is stable around the clk_inh falling edge.
REQ-008 SHALL have port rev_sw, input, 1, meaning the reverb mix enable; it is asynchronous.
REQ-009 SHALL have port frame_req, input, 1, meaning the serializer data request, a level that is high for at least 2 mclk cycles.
REQ-010 SHALL have port frame_data, output, 32, meaning {left, right} for the serializer.
REQ-011 SHALL have port fifo_level, output, 2, meaning the number of frames currently buffered.
REQ-012 SHALL have port overrun, output, 1, meaning a sticky flag that a frame was dropped because the FIFO was full.
REQ-013 SHALL have port underrun, output, 1, meaning a sticky flag that a request arrived while the FIFO was empty.
REQ-014 SHALL have port slot_err, output, 1, meaning a one-cycle pulse that an incomplete frame was discarded.

Function
REQ-015 SHALL pass clk_inh, ch_id and rev_sw each through a 2-flop synchronizer.
REQ-016 SHALL generate slot strobe: one mclk pulse on the cycle after the synchronized clk_inh goes from 1 to 0 (3 mclk cycles after the input falling edge).
REQ-017 SHALL capture dac and the synchronized ch_id on the strobe cycle, independent of FSM state.
REQ-018 SHALL use slot map 3=LSYN1, 7=RSYN1, 2=LSYN2, 6=RSYN2, 0=LREV, 1=RREV, 4=frame boundary, 5=ignored.
REQ-019 SHALL store each channel slot into its 16-bit register and set its bit in a 6-bit seen-mask; a repeated slot overwrites the register.
REQ-020 SHALL implement FSM states ALIGN, COLLECT, MIX and PUSH.
REQ-021 SHALL, in ALIGN (the reset state), ignore frame boundaries except the first slot-4 strobe, which clears the mask and moves to COLLECT with no push.
REQ-022 SHALL, in COLLECT, act on a slot-4 strobe: if mask==6'b111111, go to MIX; otherwise pulse slot_err, clear the mask and stay in COLLECT.
REQ-023 SHALL, in MIX (1 cycle), compute left/right: rev_sw=0 gives sum=SYN1; rev_sw=1 gives sum=SYN1+SYN2+REV as an 18-bit unsigned value; each output is the low 16 bits of (sum - OFFSET), wrapping with no saturation.
REQ-024 SHALL sample rev_sw (synchronized) only in MIX.
REQ-025 SHALL, in PUSH (1 cycle), write {left,right} to the FIFO, clear the mask and go to COLLECT; the frame SHALL be counted in fifo_level 2 cycles after the slot-4 strobe.
REQ-026 SHALL define a pop as the first mclk cycle on which frame_req is high after being low (rising edge, registered).
REQ-027 SHALL, on a pop with the FIFO non-empty, load frame_data with the oldest frame on the next cycle and hold it until the next pop.
REQ-028 SHALL, on a pop with the FIFO empty, set underrun and hold frame_data unchanged (repeat last frame).
REQ-029 SHALL, on a push with the FIFO full and no pop, drop the new frame and set overrun.
REQ-030 SHALL, on a simultaneous push and pop, complete both; when the FIFO is full this SHALL NOT set overrun, and when empty the pushed frame SHALL NOT bypass (the pop counts as underrun).
REQ-031 SHALL wrap the FIFO pointers modulo FIFO_DEPTH; fifo_level SHALL never exceed FIFO_DEPTH.

Reset
REQ-032 SHALL, with rst high on an mclk edge, set frame_data=0, fifo_level=0, overrun=0, underrun=0, slot_err=0, all channel registers=0, mask=0, FSM=ALIGN, and synchronizer/edge flops=0.
REQ-033 SHALL, on reset mid-frame or mid-MIX/PUSH, discard the partial frame; the first push after reset SHALL occur only after one full ALIGN→COLLECT sequence.
REQ-034 SHALL clear overrun and underrun only by reset.

Verification
REQ-035 SHALL cover: rev_sw=0, LSYN1=0x5000, RSYN1=0x6000, full slot cycle, pop → frame_data=0x10282028.
REQ-036 SHALL cover: rev_sw=1, LSYN1=LSYN2=LREV=0x4000, right channels all 0x0000 → frame_data=0x8028C028.
REQ-037 SHALL cover: slot 7 omitted from a frame → slot_err pulses once, fifo_level unchanged; the next complete frame is pushed normally.
REQ-038 SHALL cover: 3 complete frames with no pop → fifo_level=2, overrun=1; pops return frames 1 then 2.
REQ-039 SHALL cover: pop after reset before any frame → underrun=1, frame_data=0.
REQ-040 SHALL cover: rst asserted after 3 slots of a frame → all outputs 0; the first frame after the next slot 4 is discarded (ALIGN), and the second frame is pushed.
